// File: rtl/adaptive_filter_ctrl_pkg.sv
// Shared definitions for the adaptive-filter sequencer: state codes,
// watchdog width and the registered Moore output decode.
package adaptive_filter_ctrl_pkg;

    localparam int WD_W = 16;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_CLEAR     = 4'd1,
        S_LOAD      = 4'd2,
        S_FILTER    = 4'd3,
        S_ERROR     = 4'd4,
        S_UPDATE    = 4'd5,
        S_WRITEBACK = 4'd6,
        S_ITER      = 4'd7,
        S_DONE      = 4'd8,
        S_FAULT     = 4'd9
    } state_e;

    typedef struct packed {
        logic xn;
        logic dn;
        logic y;
        logic e;
        logic w;
        logic bobot;
        logic clr;
        logic busy;
        logic done;
    } ctrl_out_t;

    // States that wait on a datapath done and are guarded by the watchdog.
    function automatic logic is_wait_state(state_e s);
        return (s == S_LOAD) || (s == S_FILTER) || (s == S_ERROR) ||
               (s == S_UPDATE) || (s == S_WRITEBACK);
    endfunction

    // Moore decode; the top registers this so enables lag state by one cycle.
    function automatic ctrl_out_t decode_state(state_e s);
        ctrl_out_t o;
        o       = '0;
        o.xn    = (s == S_LOAD);
        o.dn    = (s == S_LOAD);
        o.y     = (s == S_FILTER);
        o.e     = (s == S_ERROR);
        o.w     = (s == S_UPDATE);
        o.bobot = (s == S_WRITEBACK);
        o.clr   = (s == S_CLEAR);
        o.busy  = (s != S_IDLE);
        o.done  = (s == S_DONE);
        return o;
    endfunction

endpackage

// File: rtl/adaptive_filter_ctrl_watchdog.sv
// Wait-state watchdog: counts cycles spent in the current state and flags
// expiry on the last allowed cycle so the FSM leaves after TIMEOUT cycles.
module ctrl_watchdog
    import adaptive_filter_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [WD_W-1:0] LIMIT = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0] cnt_q, cnt_d;

    // Clear on state entry, otherwise count while enabled (never wraps).
    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en && (cnt_q != '1))
            cnt_d = cnt_q + 1'b1;
    end

    // Counter register.
    always_ff @(posedge clock) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign expired = en && (cnt_q >= LIMIT);

endmodule

// File: rtl/adaptive_filter_ctrl.sv
// Sequencing FSM for the adaptive-filter datapath. Walks LOAD..WRITEBACK per
// LMS iteration, counts iterations, and falls back to CLEAR on abort/timeout.
module adaptive_filter_ctrl
    import adaptive_filter_ctrl_pkg::*;
#(
    parameter int ITER_W     = 8,
    parameter int TIMEOUT    = 255,
    parameter int CLR_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ITER_W-1:0] n_iter,
    input  logic              done_read_Xn,
    input  logic              done_read_Dn,
    input  logic              done_yn,
    input  logic              done_en,
    input  logic              done_wn1,
    input  logic              done_write_wn,
    output logic              memory_Xn_active,
    output logic              memory_Dn_active,
    output logic              y_active,
    output logic              e_active,
    output logic              w_active,
    output logic              memory_bobot_active,
    output logic              sys_reset_active,
    output logic              busy,
    output logic              done,
    output logic              err_timeout,
    output logic [ITER_W-1:0] iter_cnt,
    output logic [3:0]        state_dbg
);

    localparam int              CLR_W    = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES + 1) : 1;
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);

    state_e            state_q, state_d;
    logic              abort_path_q, abort_path_d;
    logic [ITER_W-1:0] n_iter_q, n_iter_d;
    logic [ITER_W-1:0] iter_cnt_q, iter_cnt_d;
    logic              err_q, err_d;
    logic              xn_flag_q, xn_flag_d;
    logic              dn_flag_q, dn_flag_d;
    logic [CLR_W-1:0]  clr_cnt_q, clr_cnt_d;
    ctrl_out_t         out_q, out_d;

    logic   wd_expired;
    logic   xn_seen, dn_seen;
    logic   stage_done;
    state_e stage_next;

    assign xn_seen = xn_flag_q | done_read_Xn;
    assign dn_seen = dn_flag_q | done_read_Dn;

    ctrl_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .clr     (state_d != state_q),
        .en      (is_wait_state(state_q)),
        .expired (wd_expired)
    );

    // Which done the current wait state listens to, and where it leads.
    always_comb begin
        stage_done = 1'b0;
        stage_next = state_q;
        case (state_q)
            S_LOAD:      begin stage_done = xn_seen & dn_seen; stage_next = S_FILTER;    end
            S_FILTER:    begin stage_done = done_yn;           stage_next = S_ERROR;     end
            S_ERROR:     begin stage_done = done_en;           stage_next = S_UPDATE;    end
            S_UPDATE:    begin stage_done = done_wn1;          stage_next = S_WRITEBACK; end
            S_WRITEBACK: begin stage_done = done_write_wn;     stage_next = S_ITER;      end
            default:     ;
        endcase
    end

    // Next-state, run bookkeeping and load flags.
    always_comb begin
        state_d      = state_q;
        abort_path_d = abort_path_q;
        n_iter_d     = n_iter_q;
        iter_cnt_d   = iter_cnt_q;
        err_d        = err_q;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d      = S_CLEAR;
                    abort_path_d = 1'b0;
                    n_iter_d     = n_iter;
                    iter_cnt_d   = '0;
                    err_d        = 1'b0;
                end
            end
            S_CLEAR: begin
                if (clr_cnt_q == CLR_LAST)
                    state_d = abort_path_q ? S_IDLE : S_LOAD;
            end
            S_ITER: begin
                iter_cnt_d = iter_cnt_q + 1'b1;
                if ((n_iter_q != '0) && (iter_cnt_d == n_iter_q))
                    state_d = S_DONE;
                else
                    state_d = S_LOAD;
            end
            S_DONE:  state_d = S_IDLE;
            S_FAULT: begin
                err_d        = 1'b1;
                state_d      = S_CLEAR;
                abort_path_d = 1'b1;
            end
            default: begin
                // Wait states: a done beats an expiring watchdog.
                if (stage_done)
                    state_d = stage_next;
                else if (wd_expired)
                    state_d = S_FAULT;
            end
        endcase
        // Abort overrides everything once a run is under way; CLEAR finishes itself.
        if (abort && (state_q != S_IDLE) && (state_q != S_CLEAR)) begin
            state_d      = S_CLEAR;
            abort_path_d = 1'b1;
        end
        xn_flag_d = (state_q == S_LOAD && state_d == S_LOAD) ? xn_seen : 1'b0;
        dn_flag_d = (state_q == S_LOAD && state_d == S_LOAD) ? dn_seen : 1'b0;
        clr_cnt_d = (state_q == S_CLEAR && state_d == S_CLEAR) ? clr_cnt_q + 1'b1 : '0;
        out_d     = decode_state(state_q);
    end

    // All controller state and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            abort_path_q <= 1'b0;
            n_iter_q     <= '0;
            iter_cnt_q   <= '0;
            err_q        <= 1'b0;
            xn_flag_q    <= 1'b0;
            dn_flag_q    <= 1'b0;
            clr_cnt_q    <= '0;
            out_q        <= '0;
        end else begin
            state_q      <= state_d;
            abort_path_q <= abort_path_d;
            n_iter_q     <= n_iter_d;
            iter_cnt_q   <= iter_cnt_d;
            err_q        <= err_d;
            xn_flag_q    <= xn_flag_d;
            dn_flag_q    <= dn_flag_d;
            clr_cnt_q    <= clr_cnt_d;
            out_q        <= out_d;
        end
    end

    assign memory_Xn_active    = out_q.xn;
    assign memory_Dn_active    = out_q.dn;
    assign y_active            = out_q.y;
    assign e_active            = out_q.e;
    assign w_active            = out_q.w;
    assign memory_bobot_active = out_q.bobot;
    assign sys_reset_active    = out_q.clr;
    assign busy                = out_q.busy;
    assign done                = out_q.done;
    assign err_timeout         = err_q;
    assign iter_cnt            = iter_cnt_q;
    assign state_dbg           = state_q;

endmodule

// File: tb/tb_adaptive_filter_ctrl.sv
// Bench for adaptive_filter_ctrl: a datapath model answers each enable after a
// chosen delay; expected enable window lengths, counts and flags come from
// simple arithmetic on those delays.
module tb_adaptive_filter_ctrl;

    localparam int ITER_W = 8;
    localparam int TMO    = 10;
    localparam int CLRN   = 2;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [ITER_W-1:0] n_iter = '0;
    wire               done_read_Xn, done_read_Dn, done_yn, done_en, done_wn1, done_write_wn;
    logic              memory_Xn_active, memory_Dn_active, y_active, e_active, w_active;
    logic              memory_bobot_active, sys_reset_active, busy, done, err_timeout;
    logic [ITER_W-1:0] iter_cnt;
    logic [3:0]        state_dbg;

    always #5 clock = ~clock;

    adaptive_filter_ctrl #(.ITER_W(ITER_W), .TIMEOUT(TMO), .CLR_CYCLES(CLRN)) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort), .n_iter(n_iter),
        .done_read_Xn(done_read_Xn), .done_read_Dn(done_read_Dn), .done_yn(done_yn),
        .done_en(done_en), .done_wn1(done_wn1), .done_write_wn(done_write_wn),
        .memory_Xn_active(memory_Xn_active), .memory_Dn_active(memory_Dn_active),
        .y_active(y_active), .e_active(e_active), .w_active(w_active),
        .memory_bobot_active(memory_bobot_active), .sys_reset_active(sys_reset_active),
        .busy(busy), .done(done), .err_timeout(err_timeout), .iter_cnt(iter_cnt),
        .state_dbg(state_dbg)
    );

    // Datapath model: pulse done i once the matching enable has been seen high dly[i] times.
    int   dly [6];
    bit   hold[6];
    bit   inj [6];
    int   dcnt[6];
    logic [5:0] fire = '0;
    always @(negedge clock) begin
        logic [5:0] en_v;
        en_v = {memory_bobot_active, w_active, e_active, y_active, memory_Dn_active, memory_Xn_active};
        for (int i = 0; i < 6; i++) begin
            if (en_v[i]) dcnt[i]++; else dcnt[i] = 0;
            fire[i] = en_v[i] && (dcnt[i] == dly[i]) && !hold[i];
        end
    end
    assign done_read_Xn  = fire[0] | inj[0];
    assign done_read_Dn  = fire[1] | inj[1];
    assign done_yn       = fire[2] | inj[2];
    assign done_en       = fire[3] | inj[3];
    assign done_wn1      = fire[4] | inj[4];
    assign done_write_wn = fire[5] | inj[5];

    // Monitor: lengths of every high window of the enables and sys_reset_active.
    int win_q[7][$];
    int run_len[7];
    int done_cnt = 0, done_len = 0, done_max = 0, viol = 0;
    always @(negedge clock) begin
        logic [6:0] sig;
        int hot;
        sig = {sys_reset_active, memory_bobot_active, w_active, e_active, y_active,
               memory_Dn_active, memory_Xn_active};
        for (int i = 0; i < 7; i++) begin
            if (sig[i]) run_len[i]++;
            else if (run_len[i] != 0) begin win_q[i].push_back(run_len[i]); run_len[i] = 0; end
        end
        if (done) begin done_cnt++; done_len++; end
        else begin if (done_len > done_max) done_max = done_len; done_len = 0; end
        hot = int'(memory_Xn_active | memory_Dn_active) + int'(y_active) + int'(e_active) +
              int'(w_active) + int'(memory_bobot_active) + int'(sys_reset_active);
        if (hot > 1 || memory_Xn_active != memory_Dn_active) viol++;
    end

    int passed = 0, total = 0;
    int base[7];
    int done_base;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic snap();
        for (int i = 0; i < 7; i++) base[i] = win_q[i].size();
        done_base = done_cnt;
    endtask

    task automatic pulse_start(input int n);
        n_iter = ITER_W'(n);
        start  = 1'b1;
        step();
        start  = 1'b0;
    endtask

    task automatic wait_idle();
        int ok;
        ok = 0;
        for (int c = 0; c < 3000 && ok == 0; c++) begin
            step();
            if (state_dbg == 4'd0 && !busy) ok = 1;
        end
        chk("reach_idle", ok, 1);
        step();
        step();
    endtask

    // Expected windows for a run that completes n iterations.
    task automatic check_full_run(input string tag, input int n);
        int lload;
        lload = ((dly[0] > dly[1]) ? dly[0] : dly[1]) + 1;
        chk({tag, "_done_pulses"}, done_cnt - done_base, 1);
        chk({tag, "_iter_cnt"}, int'(iter_cnt), n);
        chk({tag, "_err"}, int'(err_timeout), 0);
        chk({tag, "_clr_windows"}, win_q[6].size() - base[6], 1);
        if (win_q[6].size() > base[6]) chk({tag, "_clr_len"}, win_q[6][base[6]], CLRN);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("%s_en%0d_windows", tag, i), win_q[i].size() - base[i], n);
            for (int k = base[i]; k < win_q[i].size(); k++)
                chk($sformatf("%s_en%0d_len", tag, i), win_q[i][k],
                    (i < 2) ? lload : dly[i] + 1);
        end
    endtask

    initial begin
        int n, ok;
        for (int i = 0; i < 6; i++) begin dly[i] = 2; hold[i] = 0; inj[i] = 0; end
        step(); step();
        reset = 1'b0;
        step();
        // Reset state.
        chk("reset_outputs", int'({memory_Xn_active, memory_Dn_active, y_active, e_active, w_active,
                                   memory_bobot_active, sys_reset_active, busy, done, err_timeout}), 0);
        chk("reset_iter", int'(iter_cnt), 0);
        chk("reset_state", int'(state_dbg), 0);

        // Basic run: 3 iterations, every stage answers 2 cycles after its enable.
        snap();
        pulse_start(3);
        wait_idle();
        check_full_run("basic", 3);

        // Dn finishes 4 cycles before Xn: LOAD holds for Xn.
        dly[0] = 6; dly[1] = 2;
        snap();
        pulse_start(1);
        wait_idle();
        check_full_run("dn_early", 1);

        // Randomized runs.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 6; i++) dly[i] = $urandom_range(1, 6);
            n = $urandom_range(1, 5);
            snap();
            pulse_start(n);
            wait_idle();
            check_full_run($sformatf("rand%0d", r), n);
        end

        // Timeout: error stage never answers.
        for (int i = 0; i < 6; i++) dly[i] = 2;
        hold[3] = 1;
        snap();
        pulse_start(2);
        wait_idle();
        hold[3] = 0;
        chk("tmo_err", int'(err_timeout), 1);
        chk("tmo_done_pulses", done_cnt - done_base, 0);
        chk("tmo_iter", int'(iter_cnt), 0);
        chk("tmo_e_windows", win_q[3].size() - base[3], 1);
        if (win_q[3].size() > base[3]) chk("tmo_e_len", win_q[3][base[3]], TMO);
        chk("tmo_w_windows", win_q[4].size() - base[4], 0);
        chk("tmo_clr_windows", win_q[6].size() - base[6], 2);
        if (win_q[6].size() > base[6] + 1) chk("tmo_clr2_len", win_q[6][base[6] + 1], CLRN);

        // Endless run aborted after 5 iterations; start also clears err_timeout.
        for (int i = 0; i < 6; i++) dly[i] = 1;
        snap();
        pulse_start(0);
        ok = 0;
        for (int c = 0; c < 3000 && ok == 0; c++) begin
            step();
            if (int'(iter_cnt) == 5) ok = 1;
        end
        chk("abort_reach5", ok, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        wait_idle();
        chk("abort_iter", int'(iter_cnt), 5);
        chk("abort_done_pulses", done_cnt - done_base, 0);
        chk("abort_err", int'(err_timeout), 0);
        chk("abort_clr_windows", win_q[6].size() - base[6], 2);

        // Start while busy and a spurious done_yn during UPDATE are ignored.
        for (int i = 0; i < 6; i++) dly[i] = 3;
        dly[4] = 5;
        snap();
        pulse_start(2);
        ok = 0;
        for (int c = 0; c < 500 && ok == 0; c++) begin
            step();
            if (w_active) ok = 1;
        end
        chk("spur_reach_update", ok, 1);
        start = 1'b1; inj[2] = 1;
        step();
        start = 1'b0; inj[2] = 0;
        wait_idle();
        check_full_run("spur", 2);

        // Synchronous reset in the middle of UPDATE, then a clean run.
        for (int i = 0; i < 6; i++) dly[i] = 2;
        pulse_start(3);
        ok = 0;
        for (int c = 0; c < 500 && ok == 0; c++) begin
            step();
            if (w_active) ok = 1;
        end
        chk("rst_reach_update", ok, 1);
        reset = 1'b1;
        step();
        chk("rst_outputs", int'({memory_Xn_active, memory_Dn_active, y_active, e_active, w_active,
                                 memory_bobot_active, sys_reset_active, busy, done, err_timeout}), 0);
        chk("rst_state", int'(state_dbg), 0);
        chk("rst_iter", int'(iter_cnt), 0);
        reset = 1'b0;
        step();
        snap();
        pulse_start(1);
        wait_idle();
        check_full_run("post_rst", 1);

        chk("done_pulse_width", done_max, 1);
        chk("enable_exclusive", viol, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
